// File: rtl/mem_burst_arbiter.sv
// Arbitrates the shared memory port between I-cache and D-cache and runs each grant as a fixed-length word burst.
// Optional macro MEM_ARB_ROUND_ROBIN_EN: alternate grants under contention instead of fixed D-over-I priority.
module mem_burst_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_req,
  input  logic [ADDR_WIDTH-1:0]        i_addr,
  output logic                         i_rvalid,
  output logic [DATA_WIDTH-1:0]        i_rdata,
  output logic [$clog2(BURST_LEN)-1:0] i_beat,
  output logic                         i_done,
  input  logic                         d_req,
  input  logic                         d_we,
  input  logic [ADDR_WIDTH-1:0]        d_addr,
  input  logic [DATA_WIDTH-1:0]        d_wdata,
  output logic                         d_rvalid,
  output logic [DATA_WIDTH-1:0]        d_rdata,
  output logic [$clog2(BURST_LEN)-1:0] d_beat,
  output logic                         d_done,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_wdata,
  input  logic                         mem_ack,
  input  logic [DATA_WIDTH-1:0]        mem_rdata,
  output logic                         busy,
  output logic                         owner
);
  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam int OFF_W  = $clog2(BURST_LEN * 4);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                   state, state_n;
  logic [BEAT_W-1:0]        beat;
  logic                     owner_q;
  logic                     we_q;
  logic [ADDR_WIDTH-1:0]    base;
  logic                     grant_d;
  logic                     any_req;
  logic                     last_beat;
  logic                     beat_ack;
  logic [ADDR_WIDTH-OFF_W-1:0] sel_line;
  logic                     unused_offset_bits;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_owner;
  // Under contention the cache that did not win last time gets the port.
  assign grant_d = d_req & (~i_req | ~last_owner);
`else
  assign grant_d = d_req;
`endif

  assign any_req   = i_req | d_req;
  assign last_beat = (beat == BEAT_W'(BURST_LEN - 1));
  assign beat_ack  = (state == BURST) & mem_ack;
  assign sel_line  = grant_d ? d_addr[ADDR_WIDTH-1:OFF_W] : i_addr[ADDR_WIDTH-1:OFF_W];
  assign unused_offset_bits = ^{i_addr[OFF_W-1:0], d_addr[OFF_W-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      beat    <= '0;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      base    <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_owner <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (state == IDLE && any_req) begin
        owner_q <= grant_d;
        we_q    <= grant_d & d_we;
        base    <= {sel_line, {OFF_W{1'b0}}};
        beat    <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_owner <= grant_d;
`endif
      end else if (beat_ack) begin
        beat <= beat + 1'b1;
      end
    end
  end

  always_comb begin
    state_n   = state;
    busy      = (state == BURST);
    owner     = owner_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = base | {{(ADDR_WIDTH-BEAT_W-2){1'b0}}, beat, 2'b00};
    mem_wdata = '0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    i_beat    = '0;
    d_beat    = '0;
    i_rdata   = mem_rdata;
    d_rdata   = mem_rdata;
    case (state)
      IDLE: begin
        if (any_req) state_n = BURST;
      end
      BURST: begin
        mem_req = 1'b1;
        mem_we  = we_q;
        if (owner_q && we_q) mem_wdata = d_wdata;
        if (owner_q) begin
          d_beat   = beat;
          d_rvalid = mem_ack & ~we_q;
          d_done   = mem_ack & last_beat;
        end else begin
          i_beat   = beat;
          i_rvalid = mem_ack & ~we_q;
          i_done   = mem_ack & last_beat;
        end
        // The final acked beat closes the burst; IDLE always follows for re-arbitration.
        if (mem_ack && last_beat) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Scoreboard bench for mem_burst_arbiter: stimulus queues expected beats, a negedge monitor checks every memory cycle.
module tb_mem_burst_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_rvalid, d_rvalid, i_done, d_done;
  logic [31:0] i_rdata, d_rdata;
  logic [1:0]  i_beat, d_beat;
  logic        mem_req, mem_we, mem_ack, busy, owner;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  bit ack_always = 1'b0;
  bit ack_alt    = 1'b0;
  bit phase      = 1'b0;
  int checks     = 0;
  int failures   = 0;
  int busy_cnt   = 0;

  typedef struct {
    bit          own;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          beat;
    bit          last;
    logic [31:0] rdata;
  } exp_t;
  exp_t q[$];

  mem_burst_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .i_beat(i_beat), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_beat(d_beat), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;
  always @(posedge clk) phase <= ~phase;

  assign mem_ack   = mem_req & (ack_always | (ack_alt & phase));
  assign mem_rdata = {16'h5A5A, mem_addr[15:0]};
  assign d_wdata   = 32'hA0 + {30'd0, d_beat};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_burst(input bit own, input bit we, input logic [31:0] base, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.own   = own;
      e.we    = we;
      e.addr  = base + 32'(4 * k);
      e.wdata = (own && we) ? 32'hA0 + 32'(k) : 32'h0;
      e.beat  = k;
      e.last  = (k == 3);
      e.rdata = {16'h5A5A, e.addr[15:0]};
      q.push_back(e);
    end
  endtask

  // Monitor: checks each memory-facing cycle against the head of the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busy_cnt++;
      if (mem_req) begin
        if (q.size() == 0) begin
          chk("unexpected_burst_cycle", 32'(mem_addr), 32'hFFFF_FFFF);
        end else begin
          chk("mem_addr", mem_addr, q[0].addr);
          chk("mem_we", 32'(mem_we), 32'(q[0].we));
          chk("mem_wdata", mem_wdata, q[0].wdata);
          chk("owner", 32'(owner), 32'(q[0].own));
          chk("owner_beat", 32'(q[0].own ? d_beat : i_beat), 32'(q[0].beat));
          chk("other_beat", 32'(q[0].own ? i_beat : d_beat), 32'd0);
          if (mem_ack) begin
            chk("owner_rvalid", 32'(q[0].own ? d_rvalid : i_rvalid), 32'(!q[0].we));
            chk("other_rvalid", 32'(q[0].own ? i_rvalid : d_rvalid), 32'd0);
            chk("owner_done", 32'(q[0].own ? d_done : i_done), 32'(q[0].last));
            chk("other_done", 32'(q[0].own ? i_done : d_done), 32'd0);
            if (!q[0].we) chk("rdata", q[0].own ? d_rdata : i_rdata, q[0].rdata);
            void'(q.pop_front());
          end else begin
            chk("stall_quiet", {28'd0, i_rvalid, d_rvalid, i_done, d_done}, 32'd0);
          end
        end
      end else begin
        chk("idle_quiet", {27'd0, mem_we, i_rvalid, d_rvalid, i_done, d_done}, 32'd0);
      end
    end
  end

  task automatic wait_done(input bit own);
    bit seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (own ? d_done : i_done) seen = 1'b1;
    end
    if (!seen) begin
      chk(own ? "d_done_timeout" : "i_done_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk); #1;
      chk("idle_gap", {30'd0, busy, mem_req}, 32'd0);
    end
  endtask

  task automatic wait_beat(input bit own, input int b);
    bit seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(posedge clk); #1;
      if (busy && owner == own && 32'(own ? d_beat : i_beat) == 32'(b)) seen = 1'b1;
    end
    if (!seen) chk("beat_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs",
        {25'd0, busy, owner, mem_req, mem_we, i_rvalid | d_rvalid, i_done, d_done}, 32'd0);
    chk("reset_beats", {28'd0, i_beat, d_beat}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // I refill alone, ack every cycle
    ack_always = 1'b1;
    push_burst(1'b0, 1'b0, 32'h0000_1230, 4);
    i_addr = 32'h0000_1234; i_req = 1'b1; busy_cnt = 0;
    @(negedge clk);
    chk("mem_req_latency", 32'(mem_req), 32'd0);
    wait_done(1'b0);
    i_req = 1'b0;
    chk("busy_cycles", 32'(busy_cnt), 32'd4);

    // D writeback, ack on alternate cycles
    ack_always = 1'b0; ack_alt = 1'b1;
    push_burst(1'b1, 1'b1, 32'h0000_2000, 4);
    d_addr = 32'h0000_2000; d_we = 1'b1; d_req = 1'b1;
    wait_done(1'b1);
    d_req = 1'b0; d_we = 1'b0;

    // Reset restores "D first" before the contention test
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;

    // Simultaneous requests: D then I
    ack_alt = 1'b0; ack_always = 1'b1;
    push_burst(1'b1, 1'b0, 32'h0000_3000, 4);
    push_burst(1'b0, 1'b0, 32'h0000_4000, 4);
    d_addr = 32'h0000_3004; i_addr = 32'h0000_4008;
    d_req = 1'b1; i_req = 1'b1;
    wait_done(1'b1);
    d_req = 1'b0;
    wait_done(1'b0);
    i_req = 1'b0;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Both held for three bursts alternate D, I, D
    push_burst(1'b1, 1'b0, 32'h0000_3000, 4);
    push_burst(1'b0, 1'b0, 32'h0000_4000, 4);
    push_burst(1'b1, 1'b0, 32'h0000_3000, 4);
    d_req = 1'b1; i_req = 1'b1;
    wait_done(1'b1);
    wait_done(1'b0);
    wait_done(1'b1);
    d_req = 1'b0; i_req = 1'b0;
`endif

    // Reset at beat 2 of an I refill, then restart from beat 0
    push_burst(1'b0, 1'b0, 32'h0000_5000, 2);
    push_burst(1'b0, 1'b0, 32'h0000_5000, 4);
    i_addr = 32'h0000_5008; i_req = 1'b1;
    wait_beat(1'b0, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("reset_abort", {30'd0, mem_req, busy}, 32'd0);
    wait_done(1'b0);
    i_req = 1'b0;

    // d_req dropped at beat 1 with i_req pending
    push_burst(1'b1, 1'b0, 32'h0000_6000, 4);
    push_burst(1'b0, 1'b0, 32'h0000_7000, 4);
    d_addr = 32'h0000_6008; i_addr = 32'h0000_700C;
    d_we = 1'b0; d_req = 1'b1; i_req = 1'b1;
    wait_beat(1'b1, 1);
    d_req = 1'b0;
    wait_done(1'b1);
    wait_done(1'b0);
    i_req = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_burst_arbiter.md
Name: mem_burst_arbiter

Overview:
- Shares the single external memory port between I-cache line refills and D-cache line refills/writebacks in the pipelined core.
- Arbitrates between the two caches and sequences each granted transfer as a fixed-length word burst.
- Drives incrementing word addresses, counts beats, and routes read data and completion back to the owning cache.
- Sits between the cache controllers and the memory model or bus.

Parameters:
ADDR_WIDTH, 32, byte-address width
DATA_WIDTH, 32, word width (memory word = 4 bytes)
BURST_LEN, 4, words per cache line; power of two, >= 2

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_req  in  1  I-cache refill request; held until i_done
i_addr  in  ADDR_WIDTH  I-cache line address; offset bits ignored
i_rvalid  out  1  read beat valid for I-cache
i_rdata  out  DATA_WIDTH  read beat data
i_beat  out  $clog2(BURST_LEN)  beat index of current I transfer
i_done  out  1  one-cycle pulse on final I beat
d_req  in  1  D-cache request; held until d_done
d_we  in  1  1 = line writeback, 0 = refill; sampled at grant
d_addr  in  ADDR_WIDTH  D-cache line address; offset bits ignored
d_wdata  in  DATA_WIDTH  writeback word for beat d_beat
d_rvalid  out  1  read beat valid for D-cache
d_rdata  out  DATA_WIDTH  read beat data
d_beat  out  $clog2(BURST_LEN)  beat index of current D transfer
d_done  out  1  one-cycle pulse on final D beat
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  ADDR_WIDTH  word-aligned memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_ack  in  1  memory accepts (write) or returns (read) current beat
mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack
busy  out  1  burst in progress
owner  out  1  0 = I-cache, 1 = D-cache; valid while busy

Behaviour:
- Reset: state IDLE, beat counter 0, owner 0, busy 0, base address 0.
  - All of mem_req, mem_we, *_rvalid and *_done are 0.
  - Reset mid-burst abandons the burst immediately; no done pulse is issued.
- FSM has two states: IDLE and BURST.
- IDLE:
  - If any req is high at the clock edge, latch the winner's line base (address with low $clog2(BURST_LEN*4) bits cleared), owner, and mem_we (d_we for D, 0 for I).
  - Clear the beat counter and move to BURST.
  - mem_req is first asserted the cycle after the request is seen.
- Arbitration (macro absent): fixed priority, D over I. A lone requester is always granted.
- BURST:
  - mem_req = 1.
  - mem_addr = base | (beat << 2).
  - mem_we and mem_addr are stable until mem_ack.
  - mem_wdata = d_wdata when owner = D and mem_we = 1, else 0.
  - Beat advances only on a cycle with mem_ack; the memory may stall indefinitely.
- Read return (combinational pass-through):
  - owner_rvalid = mem_ack & !mem_we.
  - owner_rdata = mem_rdata.
  - The non-owner's rvalid stays 0.
  - i_rdata and d_rdata always mirror mem_rdata; consumers qualify with rvalid.
- Beat index: *_beat outputs show the current beat for the owner; the non-owner's *_beat is 0.
- Completion:
  - owner_done = mem_ack & (beat == BURST_LEN-1).
  - Same edge: state returns to IDLE and mem_req drops.
  - The mandatory IDLE cycle between bursts is where re-arbitration happens; no back-to-back grant without it.
- Requester drops req mid-burst: ignored; the burst runs to completion.
- Write data sampled per beat: the D-cache must present the word for the current d_beat combinationally.
- busy = (state == BURST).

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - A last_owner register (reset 0 = I) records each grant.
  - When both requests are high in IDLE, grant goes to the requester that is not last_owner.
  - So D goes first after reset, then the caches alternate under contention.
- Undefined: fixed D-over-I priority; no last_owner register.

Test Plan:
- I refill alone, BURST_LEN=4, i_addr=0x0000_1234, mem_ack every cycle:
  - mem_addr sequence is 0x1230, 0x1234, 0x1238, 0x123C.
  - i_rvalid is high 4 cycles with matching i_beat 0..3.
  - i_done pulses with beat 3.
  - busy is high exactly 4 cycles.
- D writeback, d_addr=0x0000_2000, d_we=1, d_wdata=0xA0+d_beat, mem_ack on alternate cycles:
  - mem_we=1 throughout.
  - mem_wdata is 0xA0..0xA3 held across the stall cycles.
  - d_rvalid is never high.
  - d_done pulses on the 4th ack.
- i_req and d_req raised in the same cycle:
  - Without the macro: D granted, then I granted after the IDLE gap.
  - With the macro and both held for three bursts: grant order D, I, D.
- Reset asserted while beat=2 of an I refill:
  - Next cycle mem_req=0, busy=0, i_done never pulses.
  - A new i_req restarts at beat 0 with the base address.
- d_req dropped at beat 1 while i_req is pending:
  - The D burst still completes 4 beats.
  - The I grant follows after one IDLE cycle.
